// File: rtl/regfile_dp.sv
// Dual-read, single-write register file for the RNBIP-2 datapath. It has an
// in-place increment mode, optional write-to-read bypass, a synchronous clear and an async reset.
module regfile_dp #(
    parameter int DW     = 8,
    parameter int AW     = 3,
    parameter bit BYPASS = 1'b1
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          sclr,
    input  logic          we,
    input  logic [2:0]    mux_sel,
    input  logic [AW-1:0] write_seg,
    input  logic [DW-1:0] A_in,
    input  logic [DW-1:0] B_in,
    input  logic [DW-1:0] OR2,
    input  logic [DW-1:0] ALU_IN,
    input  logic [DW-1:0] SP,
    input  logic [DW-1:0] mem,
    input  logic          re,
    input  logic [AW-1:0] read_seg_a,
    input  logic [AW-1:0] read_seg_b,
    output logic [DW-1:0] dataout_A,
    output logic [DW-1:0] dataout_B,
    output logic          rd_valid
);

    localparam int NREGS = 2 ** AW;

    logic [DW-1:0] regs [NREGS];
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata_a;
    logic [DW-1:0] rdata_b;

    always_comb begin
        waddr = write_seg;
        wdata = A_in;
        case (mux_sel)
            3'b000:  wdata = A_in;
            3'b001:  wdata = B_in;
            3'b010:  wdata = OR2;
            3'b011:  wdata = ALU_IN;
            3'b100: begin
                waddr = '0;
                wdata = SP;
            end
            3'b101: begin
                waddr = '0;
                wdata = B_in;
            end
            3'b110:  wdata = mem;
            default: wdata = regs[write_seg] + DW'(1);
        endcase
    end

    // With bypass, each port sees the contents as they will be after this edge.
    always_comb begin
        rdata_a = regs[read_seg_a];
        rdata_b = regs[read_seg_b];
        if (BYPASS) begin
            if (sclr) begin
                rdata_a = '0;
                rdata_b = '0;
            end else if (we) begin
                if (read_seg_a == waddr) rdata_a = wdata;
                if (read_seg_b == waddr) rdata_b = wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            dataout_A <= '0;
            dataout_B <= '0;
            rd_valid  <= 1'b0;
        end else begin
            rd_valid <= re;
            if (sclr) begin
                for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            end else if (we) begin
                regs[waddr] <= wdata;
            end
            if (re) begin
                dataout_A <= rdata_a;
                dataout_B <= rdata_b;
            end
        end
    end

endmodule

// File: tb/tb_regfile_dp.sv
// Self-checking bench for regfile_dp: it runs BYPASS=1 and BYPASS=0 instances side by side.
// Both instances are checked against an array model of the register contents.
module tb_regfile_dp;

    logic       clk = 1'b0;
    logic       clr_n = 1'b1;
    logic       sclr = 1'b0;
    logic       we = 1'b0;
    logic [2:0] mux_sel = 3'b000;
    logic [2:0] write_seg = 3'd0;
    logic [7:0] a_in = 8'h00, b_in = 8'h00, or2 = 8'h00, alu_in = 8'h00, sp = 8'h00, mem_d = 8'h00;
    logic       re = 1'b0;
    logic [2:0] read_seg_a = 3'd0, read_seg_b = 3'd0;
    logic [7:0] out_a1, out_b1, out_a0, out_b0;
    logic       valid1, valid0;

    logic [7:0] model [8];
    logic [7:0] exp_a1, exp_b1, exp_a0, exp_b0;
    logic       exp_valid;
    int         n_checks = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    regfile_dp #(.DW(8), .AW(3), .BYPASS(1'b1)) dut_byp (
        .clk(clk), .clr_n(clr_n), .sclr(sclr), .we(we), .mux_sel(mux_sel), .write_seg(write_seg),
        .A_in(a_in), .B_in(b_in), .OR2(or2), .ALU_IN(alu_in), .SP(sp), .mem(mem_d),
        .re(re), .read_seg_a(read_seg_a), .read_seg_b(read_seg_b),
        .dataout_A(out_a1), .dataout_B(out_b1), .rd_valid(valid1)
    );

    regfile_dp #(.DW(8), .AW(3), .BYPASS(1'b0)) dut_nobyp (
        .clk(clk), .clr_n(clr_n), .sclr(sclr), .we(we), .mux_sel(mux_sel), .write_seg(write_seg),
        .A_in(a_in), .B_in(b_in), .OR2(or2), .ALU_IN(alu_in), .SP(sp), .mem(mem_d),
        .re(re), .read_seg_a(read_seg_a), .read_seg_b(read_seg_b),
        .dataout_A(out_a0), .dataout_B(out_b0), .rd_valid(valid0)
    );

    task automatic checkOutput(input string tag);
        n_checks++;
        assert (out_a1 === exp_a1) else begin
            n_fail++;
            $error("[TB] FAIL %s byp.dataout_A got %h expected %h", tag, out_a1, exp_a1);
        end
        n_checks++;
        assert (out_b1 === exp_b1) else begin
            n_fail++;
            $error("[TB] FAIL %s byp.dataout_B got %h expected %h", tag, out_b1, exp_b1);
        end
        n_checks++;
        assert (out_a0 === exp_a0) else begin
            n_fail++;
            $error("[TB] FAIL %s nobyp.dataout_A got %h expected %h", tag, out_a0, exp_a0);
        end
        n_checks++;
        assert (out_b0 === exp_b0) else begin
            n_fail++;
            $error("[TB] FAIL %s nobyp.dataout_B got %h expected %h", tag, out_b0, exp_b0);
        end
        n_checks++;
        assert (valid1 === exp_valid && valid0 === exp_valid) else begin
            n_fail++;
            $error("[TB] FAIL %s rd_valid got %b/%b expected %b", tag, valid1, valid0, exp_valid);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 8; i++) model[i] = 8'h00;
        exp_a1 = 8'h00; exp_b1 = 8'h00; exp_a0 = 8'h00; exp_b0 = 8'h00;
        exp_valid = 1'b0;
    endtask

    // One clock: drive inputs, advance the model by one edge, then compare.
    // A BYPASS=1 read equals the post-edge contents; a BYPASS=0 read equals the pre-edge contents.
    task automatic applyStimulus(input logic wen, input logic [2:0] sel, input logic [2:0] wseg,
                                 input logic [7:0] wval, input logic ren, input logic [2:0] ra,
                                 input logic [2:0] rb, input logic sc, input string tag);
        logic [7:0] nxt [8];
        logic [2:0] addr;
        logic [7:0] val;
        a_in = 8'($urandom); b_in = 8'($urandom); or2 = 8'($urandom);
        alu_in = 8'($urandom); sp = 8'($urandom); mem_d = 8'($urandom);
        case (sel)
            3'd0: a_in = wval;
            3'd1: b_in = wval;
            3'd2: or2 = wval;
            3'd3: alu_in = wval;
            3'd4: sp = wval;
            3'd5: b_in = wval;
            3'd6: mem_d = wval;
            default: ;
        endcase
        we = wen; mux_sel = sel; write_seg = wseg; re = ren;
        read_seg_a = ra; read_seg_b = rb; sclr = sc;

        nxt = model;
        if (sc) begin
            for (int i = 0; i < 8; i++) nxt[i] = 8'h00;
        end else if (wen) begin
            addr = (sel == 3'd4 || sel == 3'd5) ? 3'd0 : wseg;
            case (sel)
                3'd0: val = a_in;
                3'd1: val = b_in;
                3'd2: val = or2;
                3'd3: val = alu_in;
                3'd4: val = sp;
                3'd5: val = b_in;
                3'd6: val = mem_d;
                default: val = 8'((int'(model[addr]) + 1) % 256);
            endcase
            nxt[addr] = val;
        end
        if (ren) begin
            exp_a1 = nxt[ra]; exp_b1 = nxt[rb];
            exp_a0 = model[ra]; exp_b0 = model[rb];
        end
        exp_valid = ren;

        @(posedge clk);
        #1;
        model = nxt;
        checkOutput(tag);
    endtask

    initial begin
        modelReset();
        #1 clr_n = 1'b0;
        #2 checkOutput("reset_init");
        #5 clr_n = 1'b1;

        // Mid-cycle async reset while a write is in progress
        applyStimulus(1, 3'd0, 3'd3, 8'h5A, 0, 3'd0, 3'd0, 0, "load_r3");
        applyStimulus(0, 3'd0, 3'd0, 8'h00, 1, 3'd3, 3'd3, 0, "read_r3");
        we = 1'b1; mux_sel = 3'd0; write_seg = 3'd3; a_in = 8'hEE; re = 1'b1;
        @(negedge clk);
        #2 clr_n = 1'b0;
        #1 modelReset();
        checkOutput("reset_async");
        @(negedge clk);
        #1 clr_n = 1'b1;
        applyStimulus(0, 3'd0, 3'd0, 8'h00, 1, 3'd3, 3'd3, 0, "read_r3_after_reset");

        // Write-source modes
        applyStimulus(1, 3'd0, 3'd1, 8'h11, 0, 3'd0, 3'd0, 0, "mode000");
        applyStimulus(1, 3'd1, 3'd2, 8'h22, 0, 3'd0, 3'd0, 0, "mode001");
        applyStimulus(1, 3'd2, 3'd3, 8'h33, 0, 3'd0, 3'd0, 0, "mode010");
        applyStimulus(1, 3'd3, 3'd4, 8'h44, 0, 3'd0, 3'd0, 0, "mode011");
        applyStimulus(1, 3'd6, 3'd5, 8'h55, 0, 3'd0, 3'd0, 0, "mode110");
        applyStimulus(1, 3'd4, 3'd7, 8'h66, 0, 3'd0, 3'd0, 0, "mode100");
        applyStimulus(1, 3'd5, 3'd6, 8'h77, 0, 3'd0, 3'd0, 0, "mode101");
        applyStimulus(0, 3'd0, 3'd0, 8'h00, 1, 3'd1, 3'd2, 0, "read_r1_r2");
        applyStimulus(0, 3'd0, 3'd0, 8'h00, 1, 3'd3, 3'd4, 0, "read_r3_r4");
        applyStimulus(0, 3'd0, 3'd0, 8'h00, 1, 3'd5, 3'd0, 0, "read_r5_r0");
        applyStimulus(0, 3'd0, 3'd0, 8'h00, 1, 3'd7, 3'd6, 0, "read_r7_r6");

        // Increment wrap: 0xFE + 3 -> 0x01
        applyStimulus(1, 3'd0, 3'd2, 8'hFE, 0, 3'd0, 3'd0, 0, "load_r2_fe");
        for (int k = 0; k < 3; k++)
            applyStimulus(1, 3'd7, 3'd2, 8'h00, 1, 3'd2, 3'd2, 0, "incr_r2");
        applyStimulus(0, 3'd0, 3'd0, 8'h00, 1, 3'd2, 3'd2, 0, "read_r2_wrapped");

        // Bypass on both ports at once
        applyStimulus(1, 3'd0, 3'd4, 8'h9C, 1, 3'd4, 3'd4, 0, "bypass_r4");
        applyStimulus(0, 3'd0, 3'd0, 8'h00, 1, 3'd4, 3'd4, 0, "read_r4");

        // Read hold while re is low
        applyStimulus(0, 3'd0, 3'd0, 8'h00, 1, 3'd1, 3'd3, 0, "hold_read");
        applyStimulus(1, 3'd0, 3'd1, 8'hC1, 0, 3'd1, 3'd3, 0, "hold_1");
        applyStimulus(1, 3'd0, 3'd3, 8'hC3, 0, 3'd1, 3'd3, 0, "hold_2");

        // sclr wins over a simultaneous write
        applyStimulus(1, 3'd0, 3'd2, 8'hAA, 1, 3'd2, 3'd3, 1, "sclr_collision");
        applyStimulus(0, 3'd0, 3'd0, 8'h00, 1, 3'd2, 3'd0, 0, "read_after_sclr_a");
        applyStimulus(0, 3'd0, 3'd0, 8'h00, 1, 3'd1, 3'd4, 0, "read_after_sclr_b");

        // Random traffic
        for (int k = 0; k < 400; k++)
            applyStimulus(1'($urandom), 3'($urandom), 3'($urandom), 8'($urandom),
                          1'($urandom), 3'($urandom), 3'($urandom),
                          ($urandom_range(0, 15) == 0), "random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_dp.md
# regfile_dp

Parametrised dual-read, single-write register file for the RNBIP-2 datapath. It is the next generation of the 8×8 dual-port register block. Changes from that block:
- width and depth are parameters;
- both read addresses are selectable;
- reads are gated by an enable with a valid flag;
- optional write-to-read bypass;
- asynchronous active-low reset plus a synchronous clear;
- an in-place increment write mode.

It sits between the operand sources (OR2, ALU, SP, memory, A/B buses) and the ALU input latches.

## Interface
Parameters:
- DW, 8, data width of every register and data port
- AW, 3, address width; register count NREGS = 2**AW
- BYPASS, 1, 1 = same-cycle write forwarded to read outputs; 0 = read returns pre-write contents

Ports:
- clk  in  1  rising-edge clock
- clr_n  in  1  asynchronous active-low reset
- sclr  in  1  synchronous clear of all registers, active high
- we  in  1  write enable
- mux_sel  in  3  write source/mode select (see Operation)
- write_seg  in  AW  write address
- A_in, B_in, OR2, ALU_IN, SP, mem  in  DW each  write sources
- re  in  1  read enable
- read_seg_a  in  AW  read address, port A
- read_seg_b  in  AW  read address, port B
- dataout_A  out  DW  registered read data, port A
- dataout_B  out  DW  registered read data, port B
- rd_valid  out  1  dataout_A/B updated on the last edge

## Operation
- Storage: NREGS × DW flops, index 0 = R0.
- Write (rising edge, when we=1 and sclr=0), by mux_sel:
  - 000: R[write_seg] <- A_in
  - 001: R[write_seg] <- B_in
  - 010: R[write_seg] <- OR2
  - 011: R[write_seg] <- ALU_IN
  - 100: R0 <- SP; write_seg ignored
  - 101: R0 <- B_in; write_seg ignored
  - 110: R[write_seg] <- mem
  - 111: R[write_seg] <- R[write_seg] + 1, modulo 2**DW. All-ones wraps to 0, no carry out.
- Effective write address: 0 for modes 100/101, otherwise write_seg. The written value ("wdata") is as listed above.
- Read (rising edge, when re=1):
  - dataout_A <- R[read_seg_a]
  - dataout_B <- R[read_seg_b]
- When re=0, dataout_A/B hold their values.
- rd_valid <= re on every edge. It is 0 after reset.
- Bypass, BYPASS=1: if we=1 and re=1 and a read address equals the effective write address, that port captures wdata. With BYPASS=0 the port captures the old contents.
- Both read ports may address the same register, and both may hit the bypass in the same cycle.
- sclr=1:
  - all registers <- 0;
  - we is ignored that cycle;
  - a read in that cycle returns 0 when BYPASS=1, and old contents when BYPASS=0;
  - rd_valid follows re as normal.
- Reset, clr_n=0: immediately, independent of clk, all registers, dataout_A, dataout_B and rd_valid go to 0. This applies even mid-write or mid-read, and no partial write survives.
- Reset release is synchronised externally. The first edge with clr_n=1 is a normal cycle.

## Timing
- Write latency: 1 edge.
- Read latency: 1 edge from re/address to dataout and rd_valid.
- A write at edge N is visible to a read at edge N when BYPASS=1. It is visible at edge N+1 when BYPASS=0.
- Increment mode reads the register's value before edge N. Back-to-back increments on consecutive cycles add 1 per cycle.
- There are no combinational paths from inputs to outputs; all outputs are flop-driven.
- Priority: clr_n > sclr > we.

## Test plan
- Reset: drive clr_n=0 asynchronously mid-cycle after loading R3=0x5A. Required: dataout_A/B=0 and rd_valid=0 immediately. After release, a read of R3 with re=1 gives 0x00.
- Source modes: mux_sel 000/001/010/011/110 write 0x11/0x22/0x33/0x44/0x55 into R1..R5. Then 100 with SP=0x66 and write_seg=7, followed by 101 with B_in=0x77. Required:
  - reads return R1..R5 = 0x11..0x55;
  - R0 = 0x77;
  - R7 is unchanged at 0.
- Increment wrap: load R2=0xFE, then apply mode 111 on R2 for 3 consecutive cycles. Required: R2 = 0x01.
- Bypass: in one cycle, write R4 <- 0x9C with read_seg_a=read_seg_b=4 and re=1. Required: dataout_A=dataout_B=0x9C with BYPASS=1. With BYPASS=0 both show the previous value, and 0x9C appears on the next read.
- Read hold and valid: do a read with re=1, then pulse re=0 for 2 cycles while writing the addressed registers. Required: dataout_A/B hold their values and rd_valid sequence is 1,0,0.
- sclr collision: assert sclr=1 with we=1, mode 000, A_in=0xAA, write_seg=2. Required: all registers 0, R2=0x00 on the next read, and the write is discarded.
